branch_resolve_unit: RTL and testbench

- Counterpart of the 2-bit branch history table (BHT) on the update side.
- Records each prediction issued at fetch in a small in-order queue.
- At execute, compares the resolved outcome with the oldest recorded prediction. Drives the BHT update interface (en / write_addr / was_taken) and issues a flush/redirect to fetch on a mispredict.
- Keeps saturating statistics counters.

---
 rtl/branch_resolve_unit.sv | 155 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Update side of the 2-bit BHT: queues fetch-time predictions in order, checks each one
// against the execute-stage outcome, drives the BHT write port and redirects fetch on a miss.
module branch_resolve_unit #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned IDX_LSB = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       arst_n,

    input  logic                       pred_valid_i,
    output logic                       pred_ready_o,
    input  logic [PC_W-1:0]            pred_pc_i,
    input  logic                       pred_taken_i,
    input  logic [PC_W-1:0]            pred_target_i,

    input  logic                       res_valid_i,
    input  logic                       res_taken_i,
    input  logic [PC_W-1:0]            res_target_i,

    output logic                       upd_en_o,
    output logic [4:0]                 upd_addr_o,
    output logic                       upd_taken_o,
    output logic                       flush_o,
    output logic [PC_W-1:0]            redirect_pc_o,

    output logic [CNT_W-1:0]           branch_cnt_o,
    output logic [CNT_W-1:0]           mispred_cnt_o,
    output logic                       underflow_err_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // Prediction storage; contents are only meaningful between head and tail.
    logic [PC_W-1:0] pc_q     [DEPTH];
    logic            taken_q  [DEPTH];
    logic [PC_W-1:0] target_q [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic             upd_en_q;
    logic [4:0]       upd_addr_q;
    logic             upd_taken_q;
    logic             flush_q;
    logic [PC_W-1:0]  redirect_pc_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic             underflow_q;

    logic            head_taken;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] head_target;
    logic            res_hit;
    logic            res_empty;
    logic            mispredict;
    logic            push;
    logic [PC_W-1:0] redirect_next;

    assign head_pc     = pc_q[head_q];
    assign head_taken  = taken_q[head_q];
    assign head_target = target_q[head_q];

    assign pred_ready_o = (count_q != FullCnt);
    assign res_hit      = res_valid_i && (count_q != '0);
    assign res_empty    = res_valid_i && (count_q == '0);

    assign mispredict = res_hit &&
                        ((res_taken_i != head_taken) ||
                         (res_taken_i && head_taken && (res_target_i != head_target)));

    // A correct resolve frees the head slot, so a simultaneous push fits even when full.
    // On a mispredict the push is wrong-path and is dropped.
    assign push = pred_valid_i && !mispredict && (pred_ready_o || res_hit);

    assign redirect_next = res_taken_i ? res_target_i : head_pc + PC_W'(4);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict) begin
            head_d  = head_q + PtrW'(1);
            tail_d  = head_q + PtrW'(1);
            count_d = '0;
        end else begin
            head_d  = head_q + PtrW'(res_hit);
            tail_d  = tail_q + PtrW'(push);
            count_d = count_q + CntW'(push) - CntW'(res_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_q]     <= pred_pc_i;
            taken_q[tail_q]  <= pred_taken_i;
            target_q[tail_q] <= pred_target_i;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            upd_en_q      <= 1'b0;
            upd_addr_q    <= '0;
            upd_taken_q   <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            upd_en_q <= res_hit;
            flush_q  <= mispredict;
            if (res_hit) begin
                upd_addr_q  <= head_pc[IDX_LSB+4:IDX_LSB];
                upd_taken_q <= res_taken_i;
                if (branch_cnt_q != CntMax) begin
                    branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                end
            end
            if (mispredict) begin
                redirect_pc_q <= redirect_next;
                if (mispred_cnt_q != CntMax) begin
                    mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
                end
            end
            if (res_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign upd_en_o        = upd_en_q;
    assign upd_addr_o      = upd_addr_q;
    assign upd_taken_o     = upd_taken_q;
    assign flush_o         = flush_q;
    assign redirect_pc_o   = redirect_pc_q;
    assign branch_cnt_o    = branch_cnt_q;
    assign mispred_cnt_o   = mispred_cnt_q;
    assign underflow_err_o = underflow_q;
    assign count_o         = count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: stimulus queues the expected BHT update per resolve,
// a monitor pops and compares whenever upd_en is seen.
module tb_branch_resolve_unit;

    logic        clk;
    logic        arst_n;
    logic        pred_valid;
    logic        pred_ready;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        upd_en;
    logic [4:0]  upd_addr;
    logic        upd_taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;
    logic        underflow_err;
    logic [2:0]  count;

    typedef struct {
        logic [4:0]  addr;
        logic        taken;
        logic        flush;
        logic [31:0] redirect;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    branch_resolve_unit #(
        .PC_W   (32),
        .DEPTH  (4),
        .IDX_LSB(2),
        .CNT_W  (16)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .pred_valid_i   (pred_valid),
        .pred_ready_o   (pred_ready),
        .pred_pc_i      (pred_pc),
        .pred_taken_i   (pred_taken),
        .pred_target_i  (pred_target),
        .res_valid_i    (res_valid),
        .res_taken_i    (res_taken),
        .res_target_i   (res_target),
        .upd_en_o       (upd_en),
        .upd_addr_o     (upd_addr),
        .upd_taken_o    (upd_taken),
        .flush_o        (flush),
        .redirect_pc_o  (redirect_pc),
        .branch_cnt_o   (branch_cnt),
        .mispred_cnt_o  (mispred_cnt),
        .underflow_err_o(underflow_err),
        .count_o        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_upd(input logic [4:0] addr, input logic taken, input logic fl,
                              input logic [31:0] redir);
        exp_t e;
        e.addr     = addr;
        e.taken    = taken;
        e.flush    = fl;
        e.redirect = redir;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, return 1 time unit after the clock edge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                        input logic [31:0] ptg, input logic rv, input logic rt,
                        input logic [31:0] rtg);
        pred_valid  = pv;
        pred_pc     = ppc;
        pred_taken  = pt;
        pred_target = ptg;
        res_valid   = rv;
        res_taken   = rt;
        res_target  = rtg;
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(1'b1, pc, t, tg, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor
    always begin
        @(posedge clk);
        #1;
        if (arst_n && upd_en) begin
            if (sb.size() == 0) begin
                check("unexpected_upd_en", 64'(upd_en), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_addr", 64'(upd_addr), 64'(e.addr));
                check("upd_taken", 64'(upd_taken), 64'(e.taken));
                check("flush", 64'(flush), 64'(e.flush));
                if (e.flush) check("redirect_pc", 64'(redirect_pc), 64'(e.redirect));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n      = 1'b0;
        pred_valid  = 1'b0;
        pred_pc     = '0;
        pred_taken  = 1'b0;
        pred_target = '0;
        res_valid   = 1'b0;
        res_taken   = 1'b0;
        res_target  = '0;
        #12;
        check("rst_count", 64'(count), 64'(0));
        check("rst_ready", 64'(pred_ready), 64'(1));
        check("rst_upd_en", 64'(upd_en), 64'(0));
        check("rst_flush", 64'(flush), 64'(0));
        check("rst_underflow", 64'(underflow_err), 64'(0));
        @(negedge clk);
        arst_n = 1'b1;

        // Correct taken prediction
        push(32'h40, 1'b1, 32'h80);
        check("t1_count_push", 64'(count), 64'(1));
        expect_upd(5'h10, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        check("t1_upd_en", 64'(upd_en), 64'(1));
        check("t1_branch_cnt", 64'(branch_cnt), 64'(1));
        check("t1_count", 64'(count), 64'(0));

        // Predicted not-taken, actually taken
        push(32'h24, 1'b0, 32'h0);
        expect_upd(5'h09, 1'b1, 1'b1, 32'h100);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
        check("t2_mispred_cnt", 64'(mispred_cnt), 64'(1));
        check("t2_branch_cnt", 64'(branch_cnt), 64'(2));
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t2_flush_one_cycle", 64'(flush), 64'(0));
        check("t2_upd_en_one_cycle", 64'(upd_en), 64'(0));

        // Fill, overflow attempt, resolve+push at full across the pointer wrap
        push(32'h100, 1'b0, 32'h0);
        push(32'h104, 1'b0, 32'h0);
        push(32'h108, 1'b0, 32'h0);
        push(32'h10C, 1'b0, 32'h0);
        check("t3_count_full", 64'(count), 64'(4));
        check("t3_ready_full", 64'(pred_ready), 64'(0));
        push(32'h200, 1'b1, 32'h300);
        check("t3_count_ignored", 64'(count), 64'(4));
        expect_upd(5'h40 & 5'h1F, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h110, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t3_count_swap", 64'(count), 64'(4));
        for (int i = 1; i <= 4; i++) begin
            expect_upd(5'(8'h40 + 8'(i)), 1'b0, 1'b0, 32'h0);
            step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        check("t3_count_drained", 64'(count), 64'(0));
        check("t3_redirect_hold", 64'(redirect_pc), 64'(32'h100));
        check("t3_branch_cnt", 64'(branch_cnt), 64'(7));

        // Taken with wrong target clears the queue and drops the concurrent push
        push(32'h300, 1'b1, 32'h80);
        push(32'h304, 1'b0, 32'h0);
        push(32'h308, 1'b0, 32'h0);
        expect_upd(5'h00, 1'b1, 1'b1, 32'h84);
        step(1'b1, 32'h30C, 1'b0, 32'h0, 1'b1, 1'b1, 32'h84);
        check("t4_count_cleared", 64'(count), 64'(0));
        check("t4_mispred_cnt", 64'(mispred_cnt), 64'(2));
        push(32'h514, 1'b0, 32'h0);
        check("t4_count_after", 64'(count), 64'(1));
        expect_upd(5'h05, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Predicted taken, actually not taken: restart at pc+4
        push(32'h61C, 1'b1, 32'h700);
        expect_upd(5'h07, 1'b0, 1'b1, 32'h620);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t4b_mispred_cnt", 64'(mispred_cnt), 64'(3));
        check("t4b_branch_cnt", 64'(branch_cnt), 64'(10));

        // Underflow
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        check("t5_underflow", 64'(underflow_err), 64'(1));
        check("t5_upd_en", 64'(upd_en), 64'(0));
        check("t5_branch_cnt", 64'(branch_cnt), 64'(10));
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t5_underflow_sticky", 64'(underflow_err), 64'(1));

        // Saturation of branch_cnt at 0xFFFF
        push(32'h40, 1'b0, 32'h0);
        for (int i = 0; i < 65525; i++) begin
            expect_upd(5'h10, 1'b0, 1'b0, 32'h0);
            step(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        check("t6_branch_at_max", 64'(branch_cnt), 64'(16'hFFFF));
        check("t6_count", 64'(count), 64'(1));
        expect_upd(5'h10, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t6_branch_saturated", 64'(branch_cnt), 64'(16'hFFFF));
        check("t6_mispred_cnt", 64'(mispred_cnt), 64'(3));

        // Asynchronous reset mid-stream with count=3
        push(32'h800, 1'b0, 32'h0);
        push(32'h804, 1'b0, 32'h0);
        push(32'h808, 1'b0, 32'h0);
        push(32'h80C, 1'b0, 32'h0);
        expect_upd(5'h00, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t7_count_pre", 64'(count), 64'(3));
        check("t7_upd_en_pre", 64'(upd_en), 64'(1));
        #2;
        arst_n = 1'b0;
        #1;
        check("t7_count", 64'(count), 64'(0));
        check("t7_upd_en", 64'(upd_en), 64'(0));
        check("t7_upd_addr", 64'(upd_addr), 64'(0));
        check("t7_redirect", 64'(redirect_pc), 64'(0));
        check("t7_branch_cnt", 64'(branch_cnt), 64'(0));
        check("t7_mispred_cnt", 64'(mispred_cnt), 64'(0));
        check("t7_underflow", 64'(underflow_err), 64'(0));
        check("t7_ready", 64'(pred_ready), 64'(1));
        @(negedge clk);
        arst_n = 1'b1;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t7_count_after", 64'(count), 64'(0));

        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
